// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and constants for the psum read router
//
// Contents:
//   psum_rd_state_t : FSM state encoding for router_psum_rd
//   GLB_RD_LATENCY  : cycles from a GLB read strobe to valid read data
package router_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_GLB  = 2'd1,
    DRAIN     = 2'd2,
    LOAD_SPAD = 2'd3
  } psum_rd_state_t;

  // The single DRAIN state in router_psum_rd absorbs exactly this latency.
  localparam int GLB_RD_LATENCY = 1;

endpackage

// File: rtl/router_psum_rd.sv
// rtl/router_psum_rd.sv - reads one psum tile from GLB and loads it into PE spads
//
// Optional feature macro: ROUTER_PSUM_RD_ZERO_INIT_EN (adds clear_psum; a
// request with clear_psum=1 loads an all-zero tile without touching GLB).
//
// Ports:
//   clk              : clock, rising edge
//   reset            : synchronous, active-high
//   load_psum_ctrl   : request to reload one psum tile (accepted only in IDLE)
//   clear_psum       : (macro only) request loads zeros instead of reading GLB
//   r_addr_glb_psum  : GLB read address
//   read_en_glb_psum : GLB read strobe
//   r_data_glb_psum  : GLB read data, valid one cycle after its strobe
//   w_data_spad_psum : psum vector to PE spads, held between loads
//   load_en_spad     : one-cycle strobe qualifying w_data_spad_psum
//   busy             : high whenever the FSM is not in IDLE
module router_psum_rd
  import router_pkg::*;
#(
  parameter int DATA_BITWIDTH     = 16,
  parameter int ADDR_BITWIDTH_GLB = 10,
  parameter int kernel_size       = 3,
  parameter int PSUM_READ_ADDR    = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_psum_ctrl,
`ifdef ROUTER_PSUM_RD_ZERO_INIT_EN
  input  logic                         clear_psum,
`endif
  output logic [ADDR_BITWIDTH_GLB-1:0] r_addr_glb_psum,
  output logic                         read_en_glb_psum,
  input  logic [DATA_BITWIDTH-1:0]     r_data_glb_psum,
  output logic [DATA_BITWIDTH-1:0]     w_data_spad_psum [0:kernel_size-1],
  output logic                         load_en_spad,
  output logic                         busy
);

  localparam int IDX_W = (kernel_size > 1) ? $clog2(kernel_size) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(kernel_size - 1);

  psum_rd_state_t r_state;
  psum_rd_state_t w_state_next;

  logic [IDX_W-1:0]         r_rd_idx;
  logic [2:0]               r_iter;
  logic                     r_cap_valid;
  logic [IDX_W-1:0]         r_cap_idx;
  logic [DATA_BITWIDTH-1:0] r_buf     [0:kernel_size-1];
  logic [DATA_BITWIDTH-1:0] r_spad    [0:kernel_size-1];
  logic [DATA_BITWIDTH-1:0] w_buf_next[0:kernel_size-1];
  logic                     w_clear_req;

`ifdef ROUTER_PSUM_RD_ZERO_INIT_EN
  assign w_clear_req = clear_psum;
`else
  assign w_clear_req = 1'b0;
`endif

  // Tile base advances by kernel_size per tile; all terms truncate to the
  // GLB address width so the region wraps around the top of GLB.
  assign r_addr_glb_psum = ADDR_BITWIDTH_GLB'(PSUM_READ_ADDR)
                         + ADDR_BITWIDTH_GLB'(r_iter) * ADDR_BITWIDTH_GLB'(kernel_size)
                         + ADDR_BITWIDTH_GLB'(r_rd_idx);

  assign w_data_spad_psum = r_spad;

  // Buffer contents including the word returning this cycle, so the final
  // word landing during DRAIN can be forwarded straight into the spad register.
  always_comb begin
    for (int i = 0; i < kernel_size; i++) begin
      w_buf_next[i] = r_buf[i];
    end
    if (r_cap_valid) begin
      w_buf_next[r_cap_idx] = r_data_glb_psum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    read_en_glb_psum = 1'b0;
    load_en_spad     = 1'b0;
    busy             = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (load_psum_ctrl) begin
          w_state_next = w_clear_req ? LOAD_SPAD : READ_GLB;
        end
      end
      READ_GLB: begin
        read_en_glb_psum = 1'b1;
        if (r_rd_idx == LAST_IDX) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        w_state_next = LOAD_SPAD;
      end
      LOAD_SPAD: begin
        load_en_spad = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_idx    <= '0;
      r_iter      <= '0;
      r_cap_valid <= 1'b0;
      r_cap_idx   <= '0;
      for (int i = 0; i < kernel_size; i++) begin
        r_buf[i]  <= '0;
        r_spad[i] <= '0;
      end
    end else begin
      // Remember which slot each issued read belongs to until its data returns.
      r_cap_valid <= read_en_glb_psum;
      r_cap_idx   <= r_rd_idx;
      for (int i = 0; i < kernel_size; i++) begin
        r_buf[i] <= w_buf_next[i];
      end

      if (r_state == READ_GLB) begin
        r_rd_idx <= (r_rd_idx == LAST_IDX) ? '0 : r_rd_idx + 1'b1;
      end else begin
        r_rd_idx <= '0;
      end

      if (r_state == LOAD_SPAD) begin
        r_iter <= r_iter + 3'd1;
      end

      // Entering LOAD_SPAD from IDLE only happens for a clear request.
      if (w_state_next == LOAD_SPAD && r_state == DRAIN) begin
        for (int i = 0; i < kernel_size; i++) begin
          r_spad[i] <= w_buf_next[i];
        end
      end else if (w_state_next == LOAD_SPAD && r_state == IDLE) begin
        for (int i = 0; i < kernel_size; i++) begin
          r_spad[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_router_psum_rd.sv
// tb/tb_router_psum_rd.sv - self-checking bench for router_psum_rd
module tb_router_psum_rd;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int K  = 3;

  typedef logic [K-1:0][DW-1:0] vec_t;
  typedef struct {int cyc; logic [AW-1:0] addr;} exp_rd_t;
  typedef struct {int cyc; vec_t vec;} exp_ld_t;
  typedef struct {int gap; logic [AW-1:0] base; vec_t vec;} row_t;

  logic          clk;
  logic          reset;
  logic          ctrl;
  logic          ctrl2;
  logic [AW-1:0] addr;
  logic [AW-1:0] addr2;
  logic          rd_en;
  logic          rd_en2;
  logic [DW-1:0] rdata;
  logic [DW-1:0] rdata2;
  logic [DW-1:0] spad  [0:K-1];
  logic [DW-1:0] spad2 [0:K-1];
  logic          ld_en;
  logic          ld_en2;
  logic          busy;
  logic          busy2;
`ifdef ROUTER_PSUM_RD_ZERO_INIT_EN
  logic          clear;
`endif

  router_psum_rd #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW), .kernel_size(K),
                   .PSUM_READ_ADDR(0)) dut (
    .clk(clk), .reset(reset), .load_psum_ctrl(ctrl),
`ifdef ROUTER_PSUM_RD_ZERO_INIT_EN
    .clear_psum(clear),
`endif
    .r_addr_glb_psum(addr), .read_en_glb_psum(rd_en), .r_data_glb_psum(rdata),
    .w_data_spad_psum(spad), .load_en_spad(ld_en), .busy(busy)
  );

  router_psum_rd #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW), .kernel_size(K),
                   .PSUM_READ_ADDR(1022)) dut2 (
    .clk(clk), .reset(reset), .load_psum_ctrl(ctrl2),
`ifdef ROUTER_PSUM_RD_ZERO_INIT_EN
    .clear_psum(1'b0),
`endif
    .r_addr_glb_psum(addr2), .read_en_glb_psum(rd_en2), .r_data_glb_psum(rdata2),
    .w_data_spad_psum(spad2), .load_en_spad(ld_en2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GLB model with one cycle read latency.
  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (rd_en)  rdata  <= mem[addr];
    if (rd_en2) rdata2 <= mem[addr2];
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tile_iter = 0;
  exp_rd_t exp_rd[$];
  exp_ld_t exp_ld[$];
  logic [AW-1:0] got2[$];
  int ld2_cnt = 0;
  vec_t got_vec;
  vec_t got_vec2;
  vec_t vec2_last;
  exp_rd_t e_rd;
  exp_ld_t e_ld;
  row_t rows[9];

  always_comb begin
    for (int i = 0; i < K; i++) begin
      got_vec[i]  = spad[i];
      got_vec2[i] = spad2[i];
    end
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", n, act, req);
    end
  endtask

  function automatic vec_t vec_of(input logic [AW-1:0] b);
    vec_t v;
    for (int i = 0; i < K; i++) v[i] = mem[AW'(b + AW'(i))];
    return v;
  endfunction

  function automatic logic [AW-1:0] base_of(input int it);
    return AW'((it % 8) * K);
  endfunction

  // Scoreboard: every read strobe and load strobe must match the expected
  // entry for exactly this cycle.
  always @(negedge clk) begin
    cyc++;
    if (rd_en) begin
      if (exp_rd.size() != 0 && exp_rd[0].cyc == cyc) begin
        e_rd = exp_rd.pop_front();
        chk("rd_addr", 64'(addr), 64'(e_rd.addr));
      end else begin
        total++; bad++;
        $display("FAIL unexpected_read cyc=%0d actual addr=%0d required no read", cyc, addr);
      end
    end
    while (exp_rd.size() != 0 && exp_rd[0].cyc <= cyc && !(rd_en && exp_rd[0].cyc == cyc)) begin
      e_rd = exp_rd.pop_front();
      total++; bad++;
      $display("FAIL missing_read cyc=%0d actual none required addr=%0d", e_rd.cyc, e_rd.addr);
    end
    if (ld_en) begin
      if (exp_ld.size() != 0 && exp_ld[0].cyc == cyc) begin
        e_ld = exp_ld.pop_front();
        chk("load_vec", 64'(got_vec), 64'(e_ld.vec));
      end else begin
        total++; bad++;
        $display("FAIL unexpected_load cyc=%0d actual vec=%0h required no load", cyc, got_vec);
      end
    end
    while (exp_ld.size() != 0 && exp_ld[0].cyc <= cyc && !(ld_en && exp_ld[0].cyc == cyc)) begin
      e_ld = exp_ld.pop_front();
      total++; bad++;
      $display("FAIL missing_load cyc=%0d actual none required vec=%0h", e_ld.cyc, e_ld.vec);
    end
  end

  always @(negedge clk) begin
    if (rd_en2) got2.push_back(addr2);
    if (ld_en2) begin
      ld2_cnt++;
      vec2_last = got_vec2;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_rd.size() != 0 || exp_ld.size() != 0) && n < 40) begin
      step();
      n++;
    end
    if (exp_rd.size() != 0 || exp_ld.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout actual pending=%0d required 0", exp_rd.size() + exp_ld.size());
      exp_rd.delete();
      exp_ld.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    exp_rd.delete();
    exp_ld.delete();
    tile_iter = 0;
  endtask

  // Issue one pulse request after gap idle cycles; gap must be >= 1 so the
  // FSM has left LOAD_SPAD.
  task automatic do_req(input int gap, input logic [AW-1:0] base, input vec_t v);
    repeat (gap) step();
    for (int i = 0; i < K; i++) exp_rd.push_back('{cyc + 1 + i, AW'(base + AW'(i))});
    exp_ld.push_back('{cyc + K + 2, v});
    ctrl = 1'b1;
    step();
    ctrl = 1'b0;
    tile_iter++;
    wait_drain();
  endtask

  initial begin
    reset = 1'b1;
    ctrl  = 1'b0;
    ctrl2 = 1'b0;
`ifdef ROUTER_PSUM_RD_ZERO_INIT_EN
    clear = 1'b0;
`endif
    for (int a = 0; a < 1024; a++) mem[a] = DW'(a * 7 + 100);
    mem[0] = 16'd10; mem[1] = 16'd20; mem[2] = 16'd30;
    mem[3] = 16'd7;  mem[4] = 16'd8;  mem[5] = 16'd9;

    // Tile table: nine tiles from reset; the ninth wraps iter back to base 0.
    for (int i = 0; i < 9; i++) begin
      rows[i].gap  = 1 + (i % 3);
      rows[i].base = AW'((i % 8) * 3);
      rows[i].vec  = vec_of(rows[i].base);
    end
    rows[0].vec[0] = 16'd10; rows[0].vec[1] = 16'd20; rows[0].vec[2] = 16'd30;
    rows[1].vec[0] = 16'd7;  rows[1].vec[1] = 16'd8;  rows[1].vec[2] = 16'd9;
    rows[8].vec = rows[0].vec;

    do_reset();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_ld_en", 64'(ld_en), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_vec", 64'(got_vec), 64'd0);
    chk("rst_addr2", 64'(addr2), 64'd1022);

    for (int i = 0; i < 9; i++) begin
      do_req(rows[i].gap, rows[i].base, rows[i].vec);
    end

    // Vector must hold between loads.
    repeat (4) step();
    chk("hold_vec", 64'(got_vec), 64'(rows[8].vec));
    chk("idle_busy", 64'(busy), 64'd0);

    // Held request: tiles accepted every 6 cycles, extra requests ignored.
    step();
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < K; i++)
        exp_rd.push_back('{cyc + 6 * t + 1 + i, AW'(base_of(tile_iter + t) + AW'(i))});
      exp_ld.push_back('{cyc + 6 * t + 5, vec_of(base_of(tile_iter + t))});
    end
    ctrl = 1'b1;
    repeat (13) step();
    ctrl = 1'b0;
    tile_iter += 3;
    wait_drain();

    // Reset during the second GLB read cycle aborts the tile.
    step();
    exp_rd.push_back('{cyc + 1, base_of(tile_iter)});
    exp_rd.push_back('{cyc + 2, AW'(base_of(tile_iter) + AW'(1))});
    ctrl = 1'b1;
    step();
    ctrl = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    tile_iter = 0;
    step();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_rd_en", 64'(rd_en), 64'd0);
    chk("abort_ld_en", 64'(ld_en), 64'd0);
    chk("abort_addr", 64'(addr), 64'd0);
    chk("abort_vec", 64'(got_vec), 64'd0);
    repeat (6) step();
    do_req(1, AW'(0), vec_of(AW'(0)));

`ifdef ROUTER_PSUM_RD_ZERO_INIT_EN
    do_reset();
    step();
    exp_ld.push_back('{cyc + 1, vec_t'(0)});
    ctrl  = 1'b1;
    clear = 1'b1;
    step();
    ctrl  = 1'b0;
    clear = 1'b0;
    tile_iter++;
    wait_drain();
    do_req(1, AW'(3), vec_of(AW'(3)));
`endif

    // Address wrap at the top of GLB on the second instance.
    step();
    ctrl2 = 1'b1;
    step();
    ctrl2 = 1'b0;
    repeat (10) step();
    chk("wrap_nreads", 64'(got2.size()), 64'd3);
    if (got2.size() == 3) begin
      chk("wrap_addr0", 64'(got2[0]), 64'd1022);
      chk("wrap_addr1", 64'(got2[1]), 64'd1023);
      chk("wrap_addr2", 64'(got2[2]), 64'd0);
    end
    chk("wrap_nloads", 64'(ld2_cnt), 64'd1);
    chk("wrap_vec", 64'(vec2_last), 64'({mem[0], mem[1023], mem[1022]}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
